power_logic_domain_seq: RTL and testbench
=========================================

POWER_LOGIC_DOMAIN_SEQ -- requirements
Module: power_logic_domain_seq

Interface
REQ-001 Parameters SHALL be:
- DEBOUNCE_CYCLES, default 8: consecutive pg_sync=1 samples needed before power-up starts; legal range 2..255.
- STEP_CYCLES, default 4: dwell cycles per sequencing step; legal range 1..255.
REQ-002 Clock and reset SHALL be: one clock; reset is asynchronous and active-low. The ports are:
- clock  in  1  block clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
REQ-003 pg_sync  in  1  synchronized domain power-good, 1=good, driven by the two-flop set-type synchronizer (reads 1 during and after reset).
REQ-004 fault_clr  in  1  single-cycle clear of fault.
REQ-005 clk_en  out  1  domain clock enable, 1=running.
REQ-006 iso_en  out  1  domain output isolation, 1=isolated.
REQ-007 domain_rstn  out  1  domain reset, active-low.
REQ-008 ready  out  1  domain fully up.
REQ-009 fault  out  1  sticky flag: power lost while in ON.

Function
REQ-010 All outputs SHALL be driven directly from flops. Each output SHALL take the value of the state entered at the same rising edge as the state change, with no combinational path from any input.
REQ-011 The FSM SHALL have the states OFF, DEBOUNCE, CLK_ON, ISO_OFF, RST_REL, ON and SHUTDOWN.
REQ-012 Output values per state, listed as clk_en/iso_en/domain_rstn/ready:
- OFF 0/1/0/0
- DEBOUNCE 0/1/0/0
- CLK_ON 1/1/0/0
- ISO_OFF 1/0/0/0
- RST_REL 1/0/1/0
- ON 1/0/1/1
- SHUTDOWN 1/1/0/0
REQ-013 In OFF, a sample of pg_sync=1 SHALL move to DEBOUNCE with the debounce count set to 1; pg_sync=0 SHALL stay in OFF.
REQ-014 In DEBOUNCE, each pg_sync=1 sample SHALL increment the count. The edge that brings the count to DEBOUNCE_CYCLES SHALL enter CLK_ON. Any pg_sync=0 sample SHALL return to OFF and clear the count.
REQ-015 CLK_ON, ISO_OFF and RST_REL SHALL each last exactly STEP_CYCLES cycles, then advance in that order to ON. The step counter SHALL restart at each state entry.
REQ-016 A pg_sync=0 sample in CLK_ON, ISO_OFF, RST_REL or ON SHALL enter SHUTDOWN at that edge and abort any step count in progress.
REQ-017 SHUTDOWN SHALL last exactly STEP_CYCLES cycles and ignore pg_sync, then enter OFF. Clocks therefore stop STEP_CYCLES cycles after isolation and reset are applied.
REQ-018 fault SHALL set on the ON->SHUTDOWN edge only. A pg_sync drop in any other state SHALL NOT set fault.
REQ-019 fault SHALL clear on an edge sampling fault_clr=1. If set and clear occur at the same edge, set SHALL win.
REQ-020 Counters SHALL be 8 bits, saturate-free within the legal parameter range, and never wrap.
REQ-021 pg_sync returning to 1 during SHUTDOWN SHALL have no effect. After OFF is entered, a full debounce SHALL be required again.

Reset
REQ-022 While resetn=0: state=OFF, both counters=0, clk_en=0, iso_en=1, domain_rstn=0, ready=0, fault=0.
REQ-023 Reset assertion at any time, including mid-sequence or in ON, SHALL force the REQ-022 values asynchronously.
REQ-024 After resetn deasserts, pg_sync=1 from the synchronizer's set state SHALL still pass a full DEBOUNCE before CLK_ON.

Verification
REQ-025 The bench SHALL cover these directed scenarios (defaults DEBOUNCE_CYCLES=8, STEP_CYCLES=4):
- Power-up: pg_sync held 1 from reset release (edge 1 = first sample) -> clk_en=1 after edge 8, iso_en=0 after edge 12, domain_rstn=1 after edge 16, ready=1 after edge 20.
- Glitch: pg_sync=1 for 5 samples, then 0 for 1, then held 1 -> returns to OFF, then clk_en rises 8 edges after pg_sync returns high; no outputs change during the glitch.
- Loss in ON: pg_sync 1->0 -> next edge gives iso_en=1, domain_rstn=0, ready=0, fault=1 with clk_en still 1; clk_en=0 four edges later; state=OFF.
- Loss in ISO_OFF: pg_sync drop at the second step cycle -> enters SHUTDOWN, fault stays 0, OFF reached 4 edges later.
- Fault clear race: fault_clr=1 on the same edge as ON->SHUTDOWN -> fault=1; fault_clr=1 one edge later -> fault=0.
- Async reset while in ON, mid-cycle -> outputs go to 0/1/0/0 and fault=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/power_logic_domain_seq.sv
// power_logic_domain_seq
//
// Power-up / power-down sequencer for one switchable logic domain.
// Waits for a debounced power-good, then walks the domain out of its
// off condition one step at a time: clocks on, isolation released,
// reset released, ready. A power-good drop after the clocks are on
// re-applies isolation and reset together, keeps the clocks running
// for STEP_CYCLES more cycles so the reset can propagate, then stops
// them. Losing power while fully up is recorded in a sticky fault flag.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive pg_sync=1 samples before power-up (2..255)
//   STEP_CYCLES      dwell cycles per sequencing step (1..255)
//
// Ports
//   clock        in   block clock, rising edge
//   resetn       in   asynchronous active-low reset
//   pg_sync      in   synchronized domain power-good, 1 = good
//   fault_clr    in   single-cycle clear of fault
//   clk_en       out  domain clock enable, 1 = running
//   iso_en       out  domain output isolation, 1 = isolated
//   domain_rstn  out  domain reset, active-low
//   ready        out  domain fully up
//   fault        out  sticky: power lost while fully up
//
// Every output is a flop. The output flops are loaded from the state
// being entered, so they change on the same edge as the state and no
// input reaches an output combinationally.

module power_logic_domain_seq #(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int STEP_CYCLES     = 4
) (
    input  logic clock,
    input  logic resetn,
    input  logic pg_sync,
    input  logic fault_clr,
    output logic clk_en,
    output logic iso_en,
    output logic domain_rstn,
    output logic ready,
    output logic fault
);

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_DEBOUNCE = 3'd1,
        ST_CLK_ON   = 3'd2,
        ST_ISO_OFF  = 3'd3,
        ST_RST_REL  = 3'd4,
        ST_ON       = 3'd5,
        ST_SHUTDOWN = 3'd6
    } state_t;

    // Debounce count value whose arrival starts power-up.
    localparam logic [7:0] DEB_TARGET = 8'(DEBOUNCE_CYCLES);
    // Step counter starts at 0 on entry, so the last dwell cycle of a
    // step is the one where it reads STEP_CYCLES-1.
    localparam logic [7:0] STEP_LAST  = 8'(STEP_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] deb_cnt_q, deb_cnt_d;
    logic [7:0] step_cnt_q, step_cnt_d;

    logic clk_en_q, clk_en_d;
    logic iso_en_q, iso_en_d;
    logic domain_rstn_q, domain_rstn_d;
    logic ready_q, ready_d;
    logic fault_q, fault_d;

    // ------------------------------------------------------------------
    // Next-state, counters and fault
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        deb_cnt_d  = deb_cnt_q;
        step_cnt_d = step_cnt_q;

        case (state_q)
            ST_OFF: begin
                deb_cnt_d  = 8'd0;
                step_cnt_d = 8'd0;
                if (pg_sync) begin
                    // The sample that leaves OFF is the first good one.
                    state_d   = ST_DEBOUNCE;
                    deb_cnt_d = 8'd1;
                end
            end

            ST_DEBOUNCE: begin
                if (!pg_sync) begin
                    state_d   = ST_OFF;
                    deb_cnt_d = 8'd0;
                end else if (deb_cnt_q + 8'd1 == DEB_TARGET) begin
                    state_d    = ST_CLK_ON;
                    deb_cnt_d  = 8'd0;
                    step_cnt_d = 8'd0;
                end else begin
                    deb_cnt_d = deb_cnt_q + 8'd1;
                end
            end

            ST_CLK_ON, ST_ISO_OFF, ST_RST_REL: begin
                if (!pg_sync) begin
                    state_d    = ST_SHUTDOWN;
                    step_cnt_d = 8'd0;
                end else if (step_cnt_q == STEP_LAST) begin
                    step_cnt_d = 8'd0;
                    case (state_q)
                        ST_CLK_ON:  state_d = ST_ISO_OFF;
                        ST_ISO_OFF: state_d = ST_RST_REL;
                        default:    state_d = ST_ON;
                    endcase
                end else begin
                    step_cnt_d = step_cnt_q + 8'd1;
                end
            end

            ST_ON: begin
                if (!pg_sync) begin
                    state_d    = ST_SHUTDOWN;
                    step_cnt_d = 8'd0;
                end
            end

            ST_SHUTDOWN: begin
                // Power-good is deliberately ignored here: the domain is
                // always taken all the way down before a new power-up.
                if (step_cnt_q == STEP_LAST) begin
                    state_d    = ST_OFF;
                    step_cnt_d = 8'd0;
                end else begin
                    step_cnt_d = step_cnt_q + 8'd1;
                end
            end

            default: begin
                state_d    = ST_OFF;
                deb_cnt_d  = 8'd0;
                step_cnt_d = 8'd0;
            end
        endcase
    end

    // Fault: clear first, then a simultaneous set overrides the clear.
    always_comb begin
        fault_d = fault_q;
        if (fault_clr) begin
            fault_d = 1'b0;
        end
        if (state_q == ST_ON && !pg_sync) begin
            fault_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output decode from the state being entered
    // ------------------------------------------------------------------
    always_comb begin
        clk_en_d      = 1'b0;
        iso_en_d      = 1'b1;
        domain_rstn_d = 1'b0;
        ready_d       = 1'b0;
        case (state_d)
            ST_CLK_ON: begin
                clk_en_d = 1'b1;
            end
            ST_ISO_OFF: begin
                clk_en_d = 1'b1;
                iso_en_d = 1'b0;
            end
            ST_RST_REL: begin
                clk_en_d      = 1'b1;
                iso_en_d      = 1'b0;
                domain_rstn_d = 1'b1;
            end
            ST_ON: begin
                clk_en_d      = 1'b1;
                iso_en_d      = 1'b0;
                domain_rstn_d = 1'b1;
                ready_d       = 1'b1;
            end
            ST_SHUTDOWN: begin
                // Clocks keep running so the re-applied reset takes effect.
                clk_en_d = 1'b1;
            end
            default: begin
                clk_en_d      = 1'b0;
                iso_en_d      = 1'b1;
                domain_rstn_d = 1'b0;
                ready_d       = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_OFF;
            deb_cnt_q     <= 8'd0;
            step_cnt_q    <= 8'd0;
            clk_en_q      <= 1'b0;
            iso_en_q      <= 1'b1;
            domain_rstn_q <= 1'b0;
            ready_q       <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            deb_cnt_q     <= deb_cnt_d;
            step_cnt_q    <= step_cnt_d;
            clk_en_q      <= clk_en_d;
            iso_en_q      <= iso_en_d;
            domain_rstn_q <= domain_rstn_d;
            ready_q       <= ready_d;
            fault_q       <= fault_d;
        end
    end

    assign clk_en      = clk_en_q;
    assign iso_en      = iso_en_q;
    assign domain_rstn = domain_rstn_q;
    assign ready       = ready_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_power_logic_domain_seq.sv
// Testbench for power_logic_domain_seq.
// Output vector layout everywhere: {clk_en, iso_en, domain_rstn, ready, fault}.

module tb_power_logic_domain_seq;

    localparam int DEB  = 8;
    localparam int STEP = 4;

    logic clock     = 1'b0;
    logic resetn    = 1'b0;
    logic pg_sync   = 1'b1;
    logic fault_clr = 1'b0;
    logic clk_en, iso_en, domain_rstn, ready, fault;

    logic [4:0] outs;
    assign outs = {clk_en, iso_en, domain_rstn, ready, fault};

    always #5 clock = ~clock;

    power_logic_domain_seq #(
        .DEBOUNCE_CYCLES(DEB),
        .STEP_CYCLES    (STEP)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .pg_sync    (pg_sync),
        .fault_clr  (fault_clr),
        .clk_en     (clk_en),
        .iso_en     (iso_en),
        .domain_rstn(domain_rstn),
        .ready      (ready),
        .fault      (fault)
    );

    int total = 0;
    int bad   = 0;

    // ------------------------------------------------------------------
    // Reference model: a coarse phase plus timestamps. The power-up
    // sequence is one phase whose sub-step is found by dividing the time
    // since it began by STEP.
    // phase: 0 off, 1 debouncing, 2 sequencing up, 3 on, 4 shutting down
    // ------------------------------------------------------------------
    int m_phase, m_run, m_t0, m_edge;
    bit m_fault;

    function automatic void model_reset();
        m_phase = 0;
        m_run   = 0;
        m_t0    = 0;
        m_edge  = 0;
        m_fault = 1'b0;
    endfunction

    function automatic void model_edge(bit pg, bit clr);
        bit set_f;
        set_f = (m_phase == 3) && !pg;
        m_edge++;
        case (m_phase)
            0: if (pg) begin m_phase = 1; m_run = 1; end
            1: begin
                if (!pg) begin
                    m_phase = 0; m_run = 0;
                end else begin
                    m_run++;
                    if (m_run == DEB) begin m_phase = 2; m_t0 = m_edge; end
                end
            end
            2, 3: begin
                if (!pg) begin
                    m_phase = 4; m_t0 = m_edge;
                end else if (m_phase == 2 && (m_edge - m_t0) == 3 * STEP) begin
                    m_phase = 3;
                end
            end
            4: if ((m_edge - m_t0) == STEP) m_phase = 0;
            default: m_phase = 0;
        endcase
        if (clr)   m_fault = 1'b0;
        if (set_f) m_fault = 1'b1;
    endfunction

    function automatic logic [4:0] model_out();
        logic [3:0] o;
        int seg;
        case (m_phase)
            2: begin
                seg = (m_edge - m_t0) / STEP;
                o = (seg == 0) ? 4'b1100 : (seg == 1) ? 4'b1000 : 4'b1010;
            end
            3:       o = 4'b1011;
            4:       o = 4'b1100;
            default: o = 4'b0100;
        endcase
        return {o, m_fault};
    endfunction

    // ------------------------------------------------------------------
    task automatic check(string name, logic [4:0] got, logic [4:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b want=%b at t=%0t", name, got, exp, $time);
        end
    endtask

    // One clock edge with the given inputs, compared against the model.
    task automatic step(bit pg, bit clr);
        pg_sync   = pg;
        fault_clr = clr;
        @(posedge clock);
        model_edge(pg, clr);
        #1;
        $display("edge %0d pg=%0b clr=%0b out=%b", m_edge, pg, clr, outs);
        check("model", outs, model_out());
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        pg_sync   = 1'b1;
        fault_clr = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_hold", outs, 5'b01000);
        #3;
        resetn = 1'b1;
        model_reset();
        #1;
        check("reset_release", outs, 5'b01000);
    endtask

    // Called just after an edge: reset asserted mid-cycle must act at once.
    task automatic async_pulse(string name);
        #3;
        resetn = 1'b0;
        #1;
        check(name, outs, 5'b01000);
        model_reset();
        #2;
        resetn = 1'b1;
    endtask

    typedef struct {
        bit         pg;
        bit         clr;
        logic [4:0] exp;
    } vec_t;

    vec_t tbl[27];

    initial begin
        int n;
        bit seg_val;
        int seg_len;

        // Power-up from reset release, then loss in ON with a clear racing
        // the fault set, clear on the next edge, pg ignored in shutdown.
        for (int e = 1; e <= 22; e++) begin
            tbl[e-1].pg  = 1'b1;
            tbl[e-1].clr = 1'b0;
            tbl[e-1].exp = (e < 8)  ? 5'b01000 :
                           (e < 12) ? 5'b11000 :
                           (e < 16) ? 5'b10000 :
                           (e < 20) ? 5'b10100 : 5'b10110;
        end
        tbl[22] = '{pg: 1'b0, clr: 1'b1, exp: 5'b11001};
        tbl[23] = '{pg: 1'b0, clr: 1'b1, exp: 5'b11000};
        tbl[24] = '{pg: 1'b1, clr: 1'b0, exp: 5'b11000};
        tbl[25] = '{pg: 1'b1, clr: 1'b0, exp: 5'b11000};
        tbl[26] = '{pg: 1'b1, clr: 1'b0, exp: 5'b01000};

        model_reset();
        do_reset();
        for (int i = 0; i < 27; i++) begin
            step(tbl[i].pg, tbl[i].clr);
            check($sformatf("vec%0d", i + 1), outs, tbl[i].exp);
        end
        // OFF re-entered: a full debounce is needed again.
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 1'b0);
            check($sformatf("redebounce%0d", k), outs, (k < 8) ? 5'b01000 : 5'b11000);
        end

        // Glitch during debounce.
        do_reset();
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("glitch_low", outs, 5'b01000);
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 1'b0);
            check($sformatf("glitch_rec%0d", k), outs, (k < 8) ? 5'b01000 : 5'b11000);
        end

        // Loss during ISO_OFF (entered at edge 12, drop sampled at edge 14).
        do_reset();
        for (int k = 0; k < 13; k++) step(1'b1, 1'b0);
        check("iso_off_in", outs, 5'b10000);
        step(1'b0, 1'b0);
        check("iso_loss", outs, 5'b11000);
        for (int k = 1; k <= 4; k++) begin
            step(1'b1, 1'b0);
            check($sformatf("iso_sd%0d", k), outs, (k < 4) ? 5'b11000 : 5'b01000);
        end

        // Async reset while in ON with fault set.
        do_reset();
        for (int k = 0; k < 21; k++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0);
        for (int k = 0; k < 21; k++) step(1'b1, 1'b0);
        check("on_with_fault", outs, 5'b10111);
        async_pulse("async_rst_on");
        step(1'b1, 1'b0);
        check("post_rst_debounce", outs, 5'b01000);

        // Randomized segments against the model.
        n = 0;
        while (n < 3000) begin
            seg_val = ($urandom_range(0, 3) != 0);
            seg_len = seg_val ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 6));
            for (int k = 0; k < seg_len; k++) begin
                step(seg_val, $urandom_range(0, 15) == 0);
            end
            n += seg_len;
            if ($urandom_range(0, 49) == 0) async_pulse("async_rst_rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
